frame_reader: RTL and testbench

Buffers the 14-bit sample stream of one utterance and reads it back as overlapping analysis frames (FRAME_LEN samples, advancing by HOP) for the windowing/FFT stage of the log-mel front end. It is the consumer-side counterpart of the sample `counter`. The `counter` writes an indexed stream of `di_en`/`data_i`. This block stores that stream and replays it frame by frame, tagging each output sample with `num` (position in frame) and `frame` (frame index).

---
 rtl/frame_reader_if.sv | 27 ++
 rtl/frame_reader.sv | 211 +++++++++++++++++++++
 tb/tb_frame_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_reader_if.sv
// Sample-stream and frame-output signals of frame_reader.
// master is the producer/observer side, slave is the frame_reader itself.
interface frame_reader_if #(
  parameter int DATA_W  = 14,
  parameter int NUM_W   = 9,
  parameter int FRAME_W = 6
);
  logic               di_en;
  logic [DATA_W-1:0]  data_i;
  logic               do_en;
  logic [DATA_W-1:0]  data_o;
  logic [NUM_W-1:0]   num;
  logic [FRAME_W-1:0] frame;
  logic               fs;
  logic               overrun;
  logic               done;

  modport master (
    output di_en, data_i,
    input  do_en, data_o, num, frame, fs, overrun, done
  );

  modport slave (
    input  di_en, data_i,
    output do_en, data_o, num, frame, fs, overrun, done
  );
endinterface

// File: rtl/frame_reader.sv
// Buffers one utterance of samples and replays it as overlapping frames
// (FRAME_LEN samples, advancing by HOP) through a 2*FRAME_LEN circular buffer.
//
// state  | meaning
// S_FILL | waiting for a frame trigger
// S_READ | issuing FRAME_LEN consecutive read addresses
// S_FIN  | last frame issued, done raised, idle until reset
module frame_reader #(
  parameter int DATA_W     = 14,
  parameter int FRAME_LEN  = 512,
  parameter int HOP        = 256,
  parameter int TOTAL_DATA = 15104
) (
  input  logic            clk,
  input  logic            rst,
  frame_reader_if.slave   bus
);

  localparam int NUM_FRAMES = (TOTAL_DATA - FRAME_LEN) / HOP + 1;
  localparam int NUM_W      = $clog2(FRAME_LEN);
  localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DEPTH      = 2 * FRAME_LEN;
  localparam int AW         = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(TOTAL_DATA + 1);

  localparam logic [CNT_W-1:0]   TOTAL_C  = CNT_W'(TOTAL_DATA);
  localparam logic [CNT_W-1:0]   FL_CNT   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]   HOP_MASK = CNT_W'(HOP - 1);
  localparam logic [AW-1:0]      FL_ADDR  = AW'(FRAME_LEN);
  localparam logic [NUM_W-1:0]   LAST_NUM = NUM_W'(FRAME_LEN - 1);
  localparam logic [FRAME_W-1:0] LAST_FRM = FRAME_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {S_FILL, S_READ, S_FIN} state_t;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [CNT_W-1:0]   r_cnt_in;
  logic [AW-1:0]      r_wptr;
  logic               r_trig;
  logic [AW-1:0]      r_trig_addr;
  logic [FRAME_W-1:0] r_trig_frame;
  logic [FRAME_W-1:0] r_frm_cnt;

  state_t             r_state;
  logic [AW-1:0]      r_raddr;
  logic [NUM_W-1:0]   r_rd_cnt;
  logic [FRAME_W-1:0] r_cur_frame;
  logic               r_pend;
  logic [AW-1:0]      r_pend_addr;
  logic [FRAME_W-1:0] r_pend_frame;

  logic               r_do_en;
  logic [DATA_W-1:0]  r_data_o;
  logic [NUM_W-1:0]   r_num;
  logic [FRAME_W-1:0] r_frame;
  logic               r_fs;
  logic               r_overrun;
  logic               r_done;

  logic               w_accept;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_hit;
  logic               w_last;
  state_t             w_state_nx;
  logic               w_load;
  logic [AW-1:0]      w_load_addr;
  logic [FRAME_W-1:0] w_load_frame;
  logic               w_pend_set;
  logic               w_pend_clr;
  logic               w_ovr_set;
  logic               w_rd_act;

  assign w_accept = bus.di_en && (r_cnt_in < TOTAL_C);
  assign w_cnt_nx = r_cnt_in + CNT_W'(1);
  // Trigger when the new count lands on FRAME_LEN + k*HOP (HOP is a power of two).
  assign w_hit    = (w_cnt_nx >= FL_CNT) && (((w_cnt_nx - FL_CNT) & HOP_MASK) == '0);
  assign w_last   = (r_rd_cnt == LAST_NUM);

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_in     <= '0;
      r_wptr       <= '0;
      r_trig       <= 1'b0;
      r_trig_addr  <= '0;
      r_trig_frame <= '0;
      r_frm_cnt    <= '0;
    end else begin
      r_trig <= w_accept && w_hit;
      if (w_accept) begin
        r_cnt_in <= w_cnt_nx;
        r_wptr   <= r_wptr + AW'(1);
      end
      // Frame index advances on every trigger, so dropped frames still consume one.
      if (w_accept && w_hit) begin
        r_trig_addr  <= r_wptr + AW'(1) - FL_ADDR;
        r_trig_frame <= r_frm_cnt;
        r_frm_cnt    <= r_frm_cnt + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_load       = 1'b0;
    w_load_addr  = r_trig_addr;
    w_load_frame = r_trig_frame;
    w_pend_set   = 1'b0;
    w_pend_clr   = 1'b0;
    w_ovr_set    = 1'b0;
    w_rd_act     = 1'b0;
    case (r_state)
      S_FILL: begin
        if (r_trig) begin
          w_state_nx = S_READ;
          w_load     = 1'b1;
        end
      end
      S_READ: begin
        w_rd_act = 1'b1;
        if (w_last) begin
          if (r_cur_frame == LAST_FRM) begin
            w_state_nx = S_FIN;
          end else if (r_pend) begin
            w_load       = 1'b1;
            w_load_addr  = r_pend_addr;
            w_load_frame = r_pend_frame;
            w_pend_clr   = 1'b1;
            w_pend_set   = r_trig;
          end else if (r_trig) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = S_FILL;
          end
        end else if (r_trig) begin
          if (r_pend) w_ovr_set  = 1'b1;
          else        w_pend_set = 1'b1;
        end
      end
      S_FIN:   w_state_nx = S_FIN;
      default: w_state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raddr      <= '0;
      r_rd_cnt     <= '0;
      r_cur_frame  <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_frame <= '0;
    end else begin
      if (w_load) begin
        r_raddr     <= w_load_addr;
        r_rd_cnt    <= '0;
        r_cur_frame <= w_load_frame;
      end else if (w_rd_act) begin
        r_raddr  <= r_raddr + AW'(1);
        r_rd_cnt <= r_rd_cnt + NUM_W'(1);
      end
      if (w_pend_set) begin
        r_pend       <= 1'b1;
        r_pend_addr  <= r_trig_addr;
        r_pend_frame <= r_trig_frame;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Output stage doubles as the synchronous read register of the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_do_en   <= 1'b0;
      r_data_o  <= '0;
      r_num     <= '0;
      r_frame   <= '0;
      r_fs      <= 1'b0;
      r_overrun <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_do_en <= w_rd_act;
      r_fs    <= w_rd_act && (r_rd_cnt == '0);
      if (w_rd_act) begin
        r_data_o <= r_mem[r_raddr];
        r_num    <= r_rd_cnt;
        r_frame  <= r_cur_frame;
      end
      r_overrun <= r_overrun | w_ovr_set;
      r_done    <= r_done | (r_state == S_FIN);
    end
  end

  assign bus.do_en   = r_do_en;
  assign bus.data_o  = r_data_o;
  assign bus.num     = r_num;
  assign bus.frame   = r_frame;
  assign bus.fs      = r_fs;
  assign bus.overrun = r_overrun;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: small instance (8/4/24) for directed
// corner cases, default instance for a full utterance.
module tb_frame_reader;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  frame_reader_if #(.DATA_W(14), .NUM_W(3), .FRAME_W(3)) ia ();
  frame_reader_if #(.DATA_W(14), .NUM_W(9), .FRAME_W(6)) ib ();

  frame_reader #(.DATA_W(14), .FRAME_LEN(8), .HOP(4), .TOTAL_DATA(24)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia)
  );

  frame_reader dut_b (
    .clk(clk), .rst(rst_b), .bus(ib)
  );

  typedef struct {
    int d;
    int num;
    int frm;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   nb_fs    = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ia.do_en === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_do_en", int'(ia.do_en), 0);
      end else begin
        ea = qa.pop_front();
        check("a_data",  int'(ia.data_o), ea.d);
        check("a_num",   int'(ia.num),    ea.num);
        check("a_frame", int'(ia.frame),  ea.frm);
        check("a_fs",    int'(ia.fs),     int'(ea.num == 0));
      end
    end
  end

  always @(negedge clk) begin
    if (ib.do_en === 1'b1) begin
      if (ib.fs === 1'b1) nb_fs++;
      if (qb.size() == 0) begin
        check("b_unexpected_do_en", int'(ib.do_en), 0);
      end else begin
        eb = qb.pop_front();
        check("b_data",  int'(ib.data_o), eb.d);
        check("b_num",   int'(ib.num),    eb.num);
        check("b_frame", int'(ib.frame),  eb.frm);
        check("b_fs",    int'(ib.fs),     int'(eb.num == 0));
      end
    end
  end

  task automatic send_a(bit en, int d);
    ia.di_en  = en;
    ia.data_i = 14'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(bit en, int d);
    ib.di_en  = en;
    ib.data_i = 14'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame_a(int k, int base, int cnt);
    for (int n = 0; n < cnt; n++) qa.push_back('{base + 4 * k + n, n, k});
  endtask

  task automatic wait_empty_a(int max, string name);
    int c;
    c = 0;
    while (qa.size() != 0 && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, qa.size(), 0);
  endtask

  task automatic wait_empty_b(int max, string name);
    int c;
    c = 0;
    while (qb.size() != 0 && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, qb.size(), 0);
  endtask

  task automatic check_zero_a(string tag);
    check({tag, "_do_en"},   int'(ia.do_en),   0);
    check({tag, "_data_o"},  int'(ia.data_o),  0);
    check({tag, "_num"},     int'(ia.num),     0);
    check({tag, "_frame"},   int'(ia.frame),   0);
    check({tag, "_fs"},      int'(ia.fs),      0);
    check({tag, "_overrun"}, int'(ia.overrun), 0);
    check({tag, "_done"},    int'(ia.done),    0);
  endtask

  task automatic pulse_reset_a();
    rst_a    = 1'b0;
    ia.di_en = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int hit;
    ia.di_en  = 1'b0;
    ia.data_i = '0;
    ib.di_en  = 1'b0;
    ib.data_i = '0;
    rst_a     = 1'b0;
    rst_b     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_a("rst");
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Eight back-to-back samples: first do_en two edges after the 8th sample.
    push_frame_a(0, 0, 8);
    for (int i = 0; i < 8; i++) send_a(1'b1, i);
    ia.di_en = 1'b0;
    check("t3_do_en_T", int'(ia.do_en), 0);
    @(posedge clk); #1;
    check("t3_do_en_T1", int'(ia.do_en), 0);
    @(posedge clk); #1;
    check("t3_do_en_T2", int'(ia.do_en), 1);
    hi = 1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ia.do_en === 1'b1) hi++;
      else break;
    end
    check("t3_do_en_len", hi, 8);
    wait_empty_a(50, "t3_drain");

    // Half-rate ramp: five continuous frames, no overrun.
    pulse_reset_a();
    for (int k = 0; k < 5; k++) push_frame_a(k, 0, 8);
    for (int i = 0; i < 24; i++) begin
      send_a(1'b1, i);
      if (i == 6) check("t1_no_early_do_en", int'(ia.do_en), 0);
      send_a(1'b0, 0);
    end
    wait_empty_a(100, "t2_drain");
    @(posedge clk); #1;
    check("t2_done",    int'(ia.done),    1);
    check("t2_overrun", int'(ia.overrun), 0);

    // Extra pulses after done are ignored.
    for (int i = 0; i < 10; i++) begin
      send_a(1'b1, 50 + i);
      send_a(1'b0, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("t6_done_held", int'(ia.done),  1);
    check("t6_no_do_en",  int'(ia.do_en), 0);

    // Full rate: frame 3 trigger finds frame 2 pending and is dropped.
    pulse_reset_a();
    push_frame_a(0, 0, 8);
    push_frame_a(1, 0, 8);
    push_frame_a(2, 0, 8);
    push_frame_a(4, 0, 8);
    for (int i = 0; i < 24; i++) send_a(1'b1, i);
    ia.di_en = 1'b0;
    wait_empty_a(100, "t4_drain");
    repeat (2) @(posedge clk);
    #1;
    check("t4_overrun", int'(ia.overrun), 1);
    check("t4_done",    int'(ia.done),    1);

    // Reset during frame 1 at num 3, then a fresh ramp from 100.
    pulse_reset_a();
    push_frame_a(0, 100, 8);
    qa.push_back('{104, 0, 1});
    qa.push_back('{105, 1, 1});
    qa.push_back('{106, 2, 1});
    hit = 0;
    for (int i = 0; i < 48 && hit == 0; i++) begin
      send_a(i % 2 == 0, 100 + i / 2);
      if (ia.do_en === 1'b1 && ia.frame == 3'd1 && ia.num == 3'd3) hit = 1;
    end
    check("t5_reached_num3", hit, 1);
    rst_a    = 1'b0;
    ia.di_en = 1'b0;
    #1;
    check_zero_a("t5_rst");
    qa.delete();
    @(posedge clk); #1;
    rst_a = 1'b1;
    for (int k = 0; k < 5; k++) push_frame_a(k, 100, 8);
    for (int i = 0; i < 24; i++) begin
      send_a(1'b1, 100 + i);
      send_a(1'b0, 0);
    end
    wait_empty_a(100, "t5_drain");
    @(posedge clk); #1;
    check("t5_done",    int'(ia.done),    1);
    check("t5_overrun", int'(ia.overrun), 0);

    // Default parameters, full utterance at half rate.
    for (int k = 0; k < 58; k++)
      for (int n = 0; n < 512; n++) qb.push_back('{k * 256 + n, n, k});
    for (int i = 0; i < 15104; i++) begin
      send_b(1'b1, i);
      send_b(1'b0, 0);
    end
    wait_empty_b(3000, "b_drain");
    repeat (2) @(posedge clk);
    #1;
    check("b_frames",  nb_fs,             58);
    check("b_done",    int'(ib.done),     1);
    check("b_overrun", int'(ib.overrun),  0);
    for (int i = 0; i < 10; i++) begin
      send_b(1'b1, i);
      send_b(1'b0, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_done_held", int'(ib.done),  1);
    check("b_no_do_en",  int'(ib.do_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
